arp_frame_tx: RTL and testbench

//  Transmit side of the ARP status path: host writes Ethernet/ARP fields through a
//  32-bit register port (same address map as the RX status read port), then pulses

---
 rtl/arp_frame_tx.sv | 179 +++++++++++++++++
 tb/tb_arp_frame_tx.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_frame_tx.sv
// ARP frame transmitter: host-written Ethernet/ARP fields are snapshotted on start and
// streamed as one FRAME_LEN-byte frame over a byte-wide valid/ready interface.
module arp_frame_tx #(
    parameter int unsigned FRAME_LEN = 60,
    parameter logic [7:0]  PAD_BYTE  = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_tx_cmd_addr,
    input  logic [31:0] i_tx_pkt_data,
    input  logic        i_tx_pkt_wr,
    input  logic        i_tx_start,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_tx_sop,
    output logic        o_tx_eop,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_start_err
);

    localparam int unsigned CW = $clog2(FRAME_LEN);

    typedef enum logic {StIdle, StSend} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;

    // Host-visible field registers
    logic [47:0] dst_mac_q, src_mac_q, sha_q, tha_q;
    logic [31:0] spa_q, tpa_q;
    logic [1:0]  pkt_type_q;

    // Per-frame snapshot, immune to host writes while sending
    logic [47:0] s_dst_q, s_src_q, s_sha_q, s_tha_q;
    logic [31:0] s_spa_q, s_tpa_q;
    logic [1:0]  s_type_q;

    logic unused_addr;
    assign unused_addr = ^i_tx_cmd_addr[7:4];

    function automatic logic [7:0] frame_byte(input int unsigned idx,
                                              input logic [47:0] dst, input logic [47:0] src,
                                              input logic [47:0] sha, input logic [31:0] spa,
                                              input logic [47:0] tha, input logic [31:0] tpa,
                                              input logic [1:0]  ptype);
        logic [7:0] b;
        b = PAD_BYTE;
        if (idx < 6)       b = 8'(dst >> (8 * (5 - idx)));
        else if (idx < 12) b = 8'(src >> (8 * (11 - idx)));
        else if (idx < 22) begin
            case (idx)
                12:      b = 8'h08;
                13:      b = 8'h06;
                14:      b = 8'h00;
                15:      b = 8'h01;
                16:      b = 8'h08;
                17:      b = 8'h00;
                18:      b = 8'h06;
                19:      b = 8'h04;
                20:      b = 8'h00;
                default: b = {6'd0, ptype};
            endcase
        end
        else if (idx < 28) b = 8'(sha >> (8 * (27 - idx)));
        else if (idx < 32) b = 8'(spa >> (8 * (31 - idx)));
        else if (idx < 38) b = 8'(tha >> (8 * (37 - idx)));
        else if (idx < 42) b = 8'(tpa >> (8 * (41 - idx)));
        return b;
    endfunction

    logic       last_byte, next_last;
    logic [7:0] start_byte, next_byte;

    always_comb begin
        last_byte  = (cnt_q == CW'(FRAME_LEN - 1));
        next_last  = (cnt_q == CW'(FRAME_LEN - 2));
        start_byte = frame_byte(0, dst_mac_q, src_mac_q, sha_q, spa_q, tha_q, tpa_q,
                                pkt_type_q);
        next_byte  = frame_byte(32'(cnt_q) + 32'd1, s_dst_q, s_src_q, s_sha_q, s_spa_q,
                                s_tha_q, s_tpa_q, s_type_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            dst_mac_q   <= '0;
            src_mac_q   <= '0;
            sha_q       <= '0;
            tha_q       <= '0;
            spa_q       <= '0;
            tpa_q       <= '0;
            pkt_type_q  <= '0;
            s_dst_q     <= '0;
            s_src_q     <= '0;
            s_sha_q     <= '0;
            s_tha_q     <= '0;
            s_spa_q     <= '0;
            s_tpa_q     <= '0;
            s_type_q    <= '0;
            o_tx_data   <= '0;
            o_tx_valid  <= 1'b0;
            o_tx_sop    <= 1'b0;
            o_tx_eop    <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_start_err <= 1'b0;
        end else begin
            o_done      <= 1'b0;
            o_start_err <= 1'b0;

            if (i_tx_pkt_wr) begin
                case (i_tx_cmd_addr[3:0])
                    4'h1:    dst_mac_q[31:0]  <= i_tx_pkt_data;
                    4'h2:    dst_mac_q[47:32] <= i_tx_pkt_data[15:0];
                    4'h3:    src_mac_q[31:0]  <= i_tx_pkt_data;
                    4'h4:    src_mac_q[47:32] <= i_tx_pkt_data[15:0];
                    4'h5:    sha_q[31:0]      <= i_tx_pkt_data;
                    4'h6:    sha_q[47:32]     <= i_tx_pkt_data[15:0];
                    4'h7:    spa_q            <= i_tx_pkt_data;
                    4'h8:    tha_q[31:0]      <= i_tx_pkt_data;
                    4'h9:    tha_q[47:32]     <= i_tx_pkt_data[15:0];
                    4'hA:    tpa_q            <= i_tx_pkt_data;
                    4'hB:    pkt_type_q       <= i_tx_pkt_data[1:0];
                    default: ;
                endcase
            end

            case (state_q)
                StIdle: begin
                    if (i_tx_start) begin
                        if (pkt_type_q == 2'd1 || pkt_type_q == 2'd2) begin
                            // Non-blocking reads give pre-write values on a same-cycle write
                            s_dst_q    <= dst_mac_q;
                            s_src_q    <= src_mac_q;
                            s_sha_q    <= sha_q;
                            s_tha_q    <= tha_q;
                            s_spa_q    <= spa_q;
                            s_tpa_q    <= tpa_q;
                            s_type_q   <= pkt_type_q;
                            cnt_q      <= '0;
                            o_tx_data  <= start_byte;
                            o_tx_valid <= 1'b1;
                            o_tx_sop   <= 1'b1;
                            o_tx_eop   <= 1'b0;
                            o_busy     <= 1'b1;
                            state_q    <= StSend;
                        end else begin
                            o_start_err <= 1'b1;
                        end
                    end
                end
                StSend: begin
                    if (o_tx_valid && i_tx_ready) begin
                        if (last_byte) begin
                            o_tx_valid <= 1'b0;
                            o_tx_sop   <= 1'b0;
                            o_tx_eop   <= 1'b0;
                            o_tx_data  <= '0;
                            o_busy     <= 1'b0;
                            o_done     <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= StIdle;
                        end else begin
                            cnt_q     <= cnt_q + 1'b1;
                            o_tx_data <= next_byte;
                            o_tx_sop  <= 1'b0;
                            o_tx_eop  <= next_last;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_arp_frame_tx.sv
// Scoreboard bench for arp_frame_tx: expected bytes queued at start, monitor pops on handshake.
module tb_arp_frame_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_tx_cmd_addr = '0;
    logic [31:0] i_tx_pkt_data = '0;
    logic        i_tx_pkt_wr = 1'b0;
    logic        i_tx_start = 1'b0;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b1;
    logic        o_tx_sop, o_tx_eop, o_busy, o_done, o_start_err;

    arp_frame_tx #(.FRAME_LEN(60), .PAD_BYTE(8'h00)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_tx_cmd_addr(i_tx_cmd_addr),
        .i_tx_pkt_data(i_tx_pkt_data),
        .i_tx_pkt_wr  (i_tx_pkt_wr),
        .i_tx_start   (i_tx_start),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .i_tx_ready   (i_tx_ready),
        .o_tx_sop     (o_tx_sop),
        .o_tx_eop     (o_tx_eop),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_start_err  (o_start_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } exp_t;

    exp_t       q[$];
    logic [7:0] rx[$];
    int         checks = 0;
    int         errors = 0;
    int         hs_count = 0;
    bit         rdy_rand = 0;
    logic       rdy_level = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Expected frame built field by field from the layout
    task automatic push_frame(input logic [47:0] dst, input logic [47:0] src,
                              input logic [47:0] sha, input logic [31:0] spa,
                              input logic [47:0] tha, input logic [31:0] tpa,
                              input logic [1:0] ptype);
        logic [7:0] b[60];
        exp_t e;
        for (int i = 0; i < 60; i++) b[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            b[i]      = dst[47-8*i -: 8];
            b[6+i]    = src[47-8*i -: 8];
            b[22+i]   = sha[47-8*i -: 8];
            b[32+i]   = tha[47-8*i -: 8];
        end
        for (int i = 0; i < 4; i++) begin
            b[28+i] = spa[31-8*i -: 8];
            b[38+i] = tpa[31-8*i -: 8];
        end
        b[12] = 8'h08; b[13] = 8'h06; b[14] = 8'h00; b[15] = 8'h01;
        b[16] = 8'h08; b[17] = 8'h00; b[18] = 8'h06; b[19] = 8'h04;
        b[20] = 8'h00; b[21] = {6'd0, ptype};
        for (int i = 0; i < 60; i++) begin
            e.d = b[i]; e.sop = (i == 0); e.eop = (i == 59);
            q.push_back(e);
        end
    endtask

    // Monitor / scoreboard
    bit         prev_stall = 0;
    bit         expect_done = 0;
    logic [9:0] prev_out;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall  = 0;
            expect_done = 0;
        end else begin
            if (expect_done) begin
                chk("done_after_eop", {o_done, o_busy, o_tx_valid}, 3'b100);
                expect_done = 0;
            end else if (o_done) begin
                chk("unexpected_done", o_done, 1'b0);
            end
            if (prev_stall && o_tx_valid)
                chk("stall_stable", {o_tx_data, o_tx_sop, o_tx_eop}, prev_out);
            if (o_tx_valid && i_tx_ready) begin
                hs_count++;
                rx.push_back(o_tx_data);
                if (q.size() == 0) begin
                    chk("unexpected_byte", {o_tx_data, o_tx_sop, o_tx_eop}, 10'h3ff);
                end else begin
                    e = q.pop_front();
                    chk("frame_byte", {o_tx_data, o_tx_sop, o_tx_eop}, {e.d, e.sop, e.eop});
                    expect_done = e.eop;
                end
            end
            prev_stall = o_tx_valid && !i_tx_ready;
            prev_out   = {o_tx_data, o_tx_sop, o_tx_eop};
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) i_tx_ready = 1'($urandom_range(0, 1));
            else          i_tx_ready = rdy_level;
        end
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        i_tx_cmd_addr = {4'h0, a};
        i_tx_pkt_data = d;
        i_tx_pkt_wr   = 1'b1;
        @(posedge clk);
        #1;
        i_tx_pkt_wr   = 1'b0;
    endtask

    task automatic write_fields(input logic [47:0] dst, input logic [47:0] src,
                                input logic [47:0] sha, input logic [31:0] spa,
                                input logic [47:0] tha, input logic [31:0] tpa,
                                input logic [1:0] ptype);
        wr(4'h1, dst[31:0]); wr(4'h2, {16'h0, dst[47:32]});
        wr(4'h3, src[31:0]); wr(4'h4, {16'h0, src[47:32]});
        wr(4'h5, sha[31:0]); wr(4'h6, {16'h0, sha[47:32]});
        wr(4'h7, spa);
        wr(4'h8, tha[31:0]); wr(4'h9, {16'h0, tha[47:32]});
        wr(4'hA, tpa);
        wr(4'hB, {30'h0, ptype});
    endtask

    task automatic start_pulse();
        i_tx_start = 1'b1;
        @(posedge clk);
        #1;
        i_tx_start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        bit seen;
        seen = 0;
        cyc  = 0;
        while (!seen && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            seen = o_done;
        end
        if (!seen) chk("done_timeout", 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
    endtask

    localparam logic [47:0] DST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC = 48'h0200_0000_0001;
    localparam logic [31:0] SPA = 32'hC0A8_0001;
    localparam logic [31:0] TPA = 32'hC0A8_0002;

    initial begin
        int cyc;
        int base;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {o_tx_data, o_tx_valid, o_tx_sop, o_tx_eop, o_busy, o_done,
                              o_start_err}, 14'h0);
        rst = 1'b0;

        // 1: full-rate frame
        write_fields(DST, SRC, SRC, SPA, 48'h0, TPA, 2'd1);
        push_frame(DST, SRC, SRC, SPA, 48'h0, TPA, 2'd1);
        rx.delete();
        base = hs_count;
        start_pulse();
        chk("t1_start_latency", {o_busy, o_tx_valid, o_tx_sop, o_tx_data}, {3'b111, 8'hFF});
        wait_done(cyc);
        chk("t1_cycles", cyc, 60);
        chk("t1_handshakes", hs_count - base, 60);
        if (rx.size() == 60) begin
            chk("t1_ethertype", {rx[12], rx[13]}, 16'h0806);
            chk("t1_oper", rx[21], 8'h01);
            chk("t1_spa", {rx[28], rx[29], rx[30], rx[31]}, 32'hC0A80001);
            chk("t1_pad", rx[59], 8'h00);
        end else chk("t1_rx_size", rx.size(), 60);

        // 2: same frame, random backpressure
        rdy_rand = 1;
        push_frame(DST, SRC, SRC, SPA, 48'h0, TPA, 2'd1);
        base = hs_count;
        start_pulse();
        wait_done(cyc);
        chk("t2_handshakes", hs_count - base, 60);
        rdy_rand  = 0;
        rdy_level = 1'b1;
        @(posedge clk);
        #1;

        // 3: writes and start during SEND must not disturb the frame
        push_frame(DST, SRC, SRC, SPA, 48'h0, TPA, 2'd1);
        rx.delete();
        start_pulse();
        repeat (10) begin @(posedge clk); #1; end
        wr(4'hA, 32'h0A00_0001);
        start_pulse();
        chk("t3_no_err", {o_start_err, o_busy}, 2'b01);
        wait_done(cyc);
        if (rx.size() == 60)
            chk("t3_old_tpa", {rx[38], rx[39], rx[40], rx[41]}, 32'hC0A80002);
        else chk("t3_rx_size", rx.size(), 60);
        push_frame(DST, SRC, SRC, SPA, 48'h0, 32'h0A00_0001, 2'd1);
        rx.delete();
        start_pulse();
        wait_done(cyc);
        if (rx.size() == 60)
            chk("t3_new_tpa", {rx[38], rx[39], rx[40], rx[41]}, 32'h0A000001);
        else chk("t3_rx_size2", rx.size(), 60);

        // 4: bad pkt_type after reset
        do_reset();
        start_pulse();
        chk("t4_err", {o_start_err, o_busy, o_tx_valid}, 3'b100);
        @(posedge clk);
        #1;
        chk("t4_err_pulse", {o_start_err, o_busy, o_tx_valid}, 3'b000);

        // 5: same-cycle type write uses the old type
        write_fields(DST, SRC, SRC, SPA, 48'h0, TPA, 2'd1);
        push_frame(DST, SRC, SRC, SPA, 48'h0, TPA, 2'd1);
        rx.delete();
        i_tx_cmd_addr = 8'h0B;
        i_tx_pkt_data = 32'd2;
        i_tx_pkt_wr   = 1'b1;
        start_pulse();
        i_tx_pkt_wr   = 1'b0;
        wait_done(cyc);
        if (rx.size() == 60) chk("t5_old_type", rx[21], 8'h01);
        else chk("t5_rx_size", rx.size(), 60);
        push_frame(DST, SRC, SRC, SPA, 48'h0, TPA, 2'd2);
        rx.delete();
        start_pulse();
        wait_done(cyc);
        if (rx.size() == 60) chk("t5_new_type", rx[21], 8'h02);
        else chk("t5_rx_size2", rx.size(), 60);

        // 6: reset mid-frame at byte 20
        push_frame(DST, SRC, SRC, SPA, 48'h0, TPA, 2'd2);
        base = hs_count;
        start_pulse();
        cyc = 0;
        while (hs_count - base < 20 && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("t6_reach_byte20", {o_tx_valid, o_tx_data}, {1'b1, 8'h00});
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_reset_outputs", {o_tx_data, o_tx_valid, o_tx_sop, o_tx_eop, o_busy, o_done,
                                 o_start_err}, 14'h0);
        rst = 1'b0;
        q.delete();
        repeat (5) begin @(posedge clk); #1; end
        start_pulse();
        chk("t6_type_cleared", o_start_err, 1'b1);
        wr(4'hB, 32'd1);
        push_frame(48'h0, 48'h0, 48'h0, 32'h0, 48'h0, 32'h0, 2'd1);
        rx.delete();
        start_pulse();
        wait_done(cyc);
        if (rx.size() == 60) chk("t6_cleared_fields", {rx[0], rx[21], rx[41]}, 24'h000100);
        else chk("t6_rx_size", rx.size(), 60);

        repeat (3) @(posedge clk);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
